// File: rtl/mux_pipe_stage.sv
// rtl/mux_pipe_stage.sv - N-way word select into a registered output with a 2-entry skid buffer.
// in_ready comes straight from the skid flag, so downstream stalls never reach upstream combinationally.
module mux_pipe_stage #(
  parameter int SIZE = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IN*SIZE-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [SIZE-1:0]        out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sel_err
);

  logic [SIZE-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [SIZE-1:0] skid_data_q, skid_data_d;
  logic            skid_valid_q, skid_valid_d;
  logic            sel_err_q, sel_err_d;

  logic [SIZE-1:0] word;
  logic            sel_ok;
  logic            accept;
  logic            slot_free;

  // Out-of-range selects (only possible for non-power-of-2 NUM_IN) match nothing and yield 0.
  always_comb begin
    word   = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word   = in_data[k*SIZE +: SIZE];
        sel_ok = 1'b1;
      end
    end
  end

  assign accept    = in_valid && !skid_valid_q;
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    sel_err_d    = sel_err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (accept && !sel_ok) begin
        sel_err_d = 1'b1;
      end
      if (slot_free) begin
        if (skid_valid_q) begin
          out_data_d   = skid_data_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          out_data_d  = word;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_data_d  = word;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: doc/mux_pipe_stage.md
# mux_pipe_stage

Parametrised N-way, SIZE-bit selection stage with a registered output and a valid/ready handshake. It selects one of NUM_IN flattened input words per transfer and holds the result in a 2-entry skid buffer, so back-pressure never creates a combinational ready path. It sits between pipeline stages of the MIPS datapath, for example for ALU operand selection (register file, EX/MEM forward, MEM/WB forward, immediate) and for write-back source selection. It replaces ad-hoc 2:1 muxes wherever the selection must be pipelined or stallable.

## Interface
Parameters:
- SIZE, 32, data word width in bits.
- NUM_IN, 4, number of input words; must be at least 2.
- SEL_W, $clog2(NUM_IN), select width; derived, never overridden.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  NUM_IN*SIZE  flattened inputs; word k is in_data[k*SIZE +: SIZE]
- sel  input  SEL_W  binary index of the word to capture; sampled with in_data
- in_valid  input  1  upstream presents in_data/sel
- in_ready  output  1  stage accepts this cycle; driven directly from a register
- flush  input  1  synchronous discard of all held entries
- out_data  output  SIZE  selected word, registered
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream consumes out_data this cycle
- sel_err  output  1  sticky flag: an out-of-range sel was accepted

## Operation
- Accept is in_valid && in_ready. Consume is out_valid && out_ready.
- Selection: word = in_data[sel*SIZE +: SIZE] when sel < NUM_IN. Otherwise word = 0 and sel_err is set. This can only happen when NUM_IN is not a power of 2.
- Storage: output register (out_data/out_valid) plus one skid register (skid_data/skid_valid).
- in_ready = !skid_valid. It is registered and never depends combinationally on out_ready.
- The output slot is free when !out_valid || out_ready. Per cycle, with flush low:
  - Slot free and skid_valid: out_data <= skid_data, out_valid <= 1, skid_valid <= 0. No accept can occur, because in_ready = 0.
  - Slot free, no skid, accept: out_data <= word, out_valid <= 1.
  - Slot free, no skid, no accept: out_valid <= 0. out_data holds its last value.
  - Slot not free and accept: skid_data <= word, skid_valid <= 1.
  - Slot not free and no accept: hold everything.
- Flush (priority over all handshakes): out_valid <= 0 and skid_valid <= 0. Any same-cycle input is dropped and sets no sel_err. Data registers keep their values. in_ready is 1 from the next cycle.
- sel_err: set on an accept with sel >= NUM_IN. It is cleared only by reset; flush does not clear it.
- Ordering is strict FIFO. Words are never duplicated or dropped except by flush or reset.

## Timing
- Reset values: out_valid=0, skid_valid=0, in_ready=1, out_data=0, skid_data=0, sel_err=0.
- Reset mid-operation discards both entries the same as flush, and also clears sel_err and the data registers.
- Latency: accept on edge N gives out_valid=1 with out_data=word after edge N, visible in cycle N+1.
- Throughput: 1 word/cycle while out_ready=1. in_ready stays 1 indefinitely.
- Stall: if out_ready drops with out_valid=1, one more word can be accepted (into skid). in_ready falls after that edge.
- Release: the first cycle with out_ready=1 moves skid to the output. in_ready returns to 1 the following cycle. No bubble appears on the output side.
- Simultaneous flush and consume: the consume completes downstream, but the stage still empties.
- Simultaneous reset and flush: reset behaviour applies.

## Test plan
- Reset, then stream: NUM_IN=4, SIZE=32, inputs {0x11111111, 0x22222222, 0x33333333, 0x44444444}, sel=0,1,2,3 on consecutive cycles with out_ready=1. Required: out_data 0x11111111..0x44444444 on cycles 1-4, out_valid continuously 1, in_ready continuously 1.
- Back-pressure: hold out_ready=0 after the first word while offering sel=1, then sel=2. Required: the sel=1 word is captured in skid, and in_ready=0 from the next cycle while sel=2 is held. Raise out_ready: outputs are 0x11111111, 0x22222222, 0x33333333 in order with no loss or duplication.
- Flush with full skid: fill both entries, then assert flush together with in_valid. Required: out_valid=0 and in_ready=1 next cycle; the same-cycle input never appears at the output.
- Out-of-range select: NUM_IN=3, accept sel=3. Required: out_data=0, sel_err=1. sel_err survives a later flush and clears only on reset.
- Reset mid-stall: with both entries full, assert reset for 1 cycle. Required: all outputs at their reset values next cycle. A new accept then yields its word with 1-cycle latency.
- Random soak: random in_valid/out_ready/sel, NUM_IN=5, SIZE=8, 10k cycles. Required: a scoreboard FIFO matches every output exactly and in_ready is never 0 while skid_valid=0.
